// File: rtl/fc_spk_sched.sv
// Layer-level event scheduler for a bank of FC neuron cores: buffers one timestep of
// input spikes, replays them to every core once per neuron slot, and serializes fired neuron ids.
module fc_spk_sched #(
    parameter int NUM_NC           = 4,
    parameter int LAYER_SIZE       = 10,
    parameter int IN_CHANNELS      = 2,
    parameter int INPUT_FRAME_SIZE = 28,
    localparam int MAX_SPK = IN_CHANNELS * INPUT_FRAME_SIZE,
    localparam int NPC_RAW = (LAYER_SIZE + NUM_NC - 1) / NUM_NC,
    localparam int NPC     = (NPC_RAW < 1) ? 1 : NPC_RAW,
    localparam int AW      = (MAX_SPK > 1) ? $clog2(MAX_SPK) : 1,
    localparam int NW      = (NPC > 1) ? $clog2(NPC) : 1,
    localparam int OW      = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1,
    localparam int CCW     = (NUM_NC > 1) ? $clog2(NUM_NC) : 1,
    localparam int CW      = $clog2(MAX_SPK + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic              in_last,
    input  logic              in_null,
    input  logic              in_final_ts,
    output logic              nc_en_accum,
    output logic              nc_en_activ,
    output logic              nc_last_time_step,
    output logic [NW-1:0]     nc_neuron,
    output logic [AW-1:0]     nc_spk_addr,
    input  logic [NUM_NC-1:0] nc_post_syn_spk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_neuron,
    output logic              ts_done,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_STREAM, S_ACTIV, S_WAIT, S_EMIT, S_DONE
    } state_t;

    localparam logic [CW-1:0]  MAX_C     = CW'(MAX_SPK);
    localparam logic [CW-1:0]  ONE_CNT   = CW'(1);
    localparam logic [NW-1:0]  LAST_PASS = NW'(NPC - 1);
    localparam logic [NW-1:0]  ONE_PASS  = NW'(1);
    localparam logic [CCW-1:0] LAST_C    = CCW'(NUM_NC - 1);
    localparam logic [CCW-1:0] ONE_C     = CCW'(1);

    // Global neuron id of core c in slot p.
    function automatic logic [OW-1:0] gid(input logic [CCW-1:0] c, input logic [NW-1:0] p);
        int v;
        v = int'(c) * NPC + int'(p);
        return v[OW-1:0];
    endfunction

    // A core's spike is reported only if its slot maps to a real neuron of the layer.
    function automatic logic hit(input logic [NUM_NC-1:0] cap, input logic [CCW-1:0] c,
                                 input logic [NW-1:0] p);
        int v;
        v = int'(c) * NPC + int'(p);
        return cap[c] && (v < LAYER_SIZE);
    endfunction

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       k_q;
    logic [NW-1:0]       pass_q;
    logic [CCW-1:0]      c_q;
    logic                wait_q;
    logic [NUM_NC-1:0]   cap_q;
    logic [AW-1:0]       spk_buf_q [MAX_SPK];
    logic                in_ready_q, en_accum_q, en_activ_q, last_ts_q;
    logic [NW-1:0]       nc_neuron_q;
    logic [AW-1:0]       spk_addr_q;
    logic                out_valid_q, ts_done_q, overflow_q;
    logic [OW-1:0]       out_neuron_q;
    logic                wr_en_s;

    // Buffer write strobe: accepted non-null beat with room left.
    always_comb begin
        if (state_q == S_LOAD && in_valid && !in_null && cnt_q != MAX_C) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Spike address buffer (data only, needs no reset).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            spk_buf_q[cnt_q[AW-1:0]] <= in_addr;
        end
    end

    // Scheduler FSM with registered core controls and output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            k_q          <= '0;
            pass_q       <= '0;
            c_q          <= '0;
            wait_q       <= 1'b0;
            cap_q        <= '0;
            in_ready_q   <= 1'b1;
            en_accum_q   <= 1'b0;
            en_activ_q   <= 1'b0;
            last_ts_q    <= 1'b0;
            nc_neuron_q  <= '0;
            spk_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_neuron_q <= '0;
            ts_done_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        if (!in_null) begin
                            if (cnt_q == MAX_C) overflow_q <= 1'b1;
                            else                cnt_q      <= cnt_q + ONE_CNT;
                        end
                        if (in_last) begin
                            last_ts_q   <= in_final_ts;
                            pass_q      <= '0;
                            nc_neuron_q <= '0;
                            en_accum_q  <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_START;
                        end
                    end
                end
                S_START: begin
                    en_accum_q <= 1'b0;
                    if (cnt_q == '0) begin
                        spk_addr_q <= '0;
                        en_activ_q <= 1'b1;
                        state_q    <= S_ACTIV;
                    end else begin
                        spk_addr_q <= spk_buf_q[0];
                        k_q        <= ONE_CNT;
                        state_q    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (k_q == cnt_q) begin
                        en_activ_q <= 1'b1;
                        state_q    <= S_ACTIV;
                    end else begin
                        spk_addr_q <= spk_buf_q[k_q[AW-1:0]];
                        k_q        <= k_q + ONE_CNT;
                    end
                end
                S_ACTIV: begin
                    en_activ_q <= 1'b0;
                    wait_q     <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // Second wait cycle: core spikes are now registered and stable.
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else begin
                        cap_q        <= nc_post_syn_spk;
                        c_q          <= '0;
                        out_valid_q  <= hit(nc_post_syn_spk, '0, pass_q);
                        out_neuron_q <= gid('0, pass_q);
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!(out_valid_q && !out_ready)) begin
                        if (c_q == LAST_C) begin
                            out_valid_q <= 1'b0;
                            if (pass_q != LAST_PASS) begin
                                pass_q      <= pass_q + ONE_PASS;
                                nc_neuron_q <= pass_q + ONE_PASS;
                                en_accum_q  <= 1'b1;
                                state_q     <= S_START;
                            end else begin
                                ts_done_q <= 1'b1;
                                state_q   <= S_DONE;
                            end
                        end else begin
                            c_q          <= c_q + ONE_C;
                            out_valid_q  <= hit(cap_q, c_q + ONE_C, pass_q);
                            out_neuron_q <= gid(c_q + ONE_C, pass_q);
                        end
                    end
                end
                S_DONE: begin
                    ts_done_q    <= 1'b0;
                    cnt_q        <= '0;
                    pass_q       <= '0;
                    last_ts_q    <= 1'b0;
                    nc_neuron_q  <= '0;
                    spk_addr_q   <= '0;
                    out_neuron_q <= '0;
                    in_ready_q   <= 1'b1;
                    state_q      <= S_LOAD;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready          = in_ready_q;
    assign nc_en_accum       = en_accum_q;
    assign nc_en_activ       = en_activ_q;
    assign nc_last_time_step = last_ts_q;
    assign nc_neuron         = nc_neuron_q;
    assign nc_spk_addr       = spk_addr_q;
    assign out_valid         = out_valid_q;
    assign out_neuron        = out_neuron_q;
    assign ts_done           = ts_done_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_fc_spk_sched.sv
// Self-checking bench for fc_spk_sched: cycle-exact schedule checks plus an output-id scoreboard.
module tb_fc_spk_sched;

    localparam int NUM_NC     = 4;
    localparam int LAYER_SIZE = 10;
    localparam int NPC        = 3;
    localparam int MAX_SPK    = 56;

    logic       clk, rst_n;
    logic       in_valid, in_ready, in_last, in_null, in_final_ts;
    logic [5:0] in_addr;
    logic       nc_en_accum, nc_en_activ, nc_last_time_step;
    logic [1:0] nc_neuron;
    logic [5:0] nc_spk_addr;
    logic [3:0] nc_post_syn_spk;
    logic       out_valid, out_ready;
    logic [3:0] out_neuron;
    logic       ts_done, overflow;

    int   tests;
    int   fails;
    int   stim_q[$];
    int   model_buf[$];
    int   exp_q[$];
    logic exp_ovf;

    fc_spk_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_last(in_last), .in_null(in_null), .in_final_ts(in_final_ts),
        .nc_en_accum(nc_en_accum), .nc_en_activ(nc_en_activ),
        .nc_last_time_step(nc_last_time_step), .nc_neuron(nc_neuron),
        .nc_spk_addr(nc_spk_addr), .nc_post_syn_spk(nc_post_syn_spk),
        .out_valid(out_valid), .out_ready(out_ready), .out_neuron(out_neuron),
        .ts_done(ts_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives stim_q as one timestep; the final beat is left on the bus for run_passes to clear.
    task automatic load_ts(input logic null_last, input logic final_ts);
        int n;
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL load_ready beat %0d: got %b want 1", i, in_ready);
            end
            in_valid = 1'b1; in_addr = 6'(stim_q[i]); in_null = 1'b0;
            in_last = (!null_last && i == n - 1); in_final_ts = final_ts;
            if (model_buf.size() < MAX_SPK) model_buf.push_back(stim_q[i]);
            else exp_ovf = 1'b1;
        end
        if (null_last) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = 6'd0; in_null = 1'b1; in_last = 1'b1; in_final_ts = final_ts;
        end
        stim_q.delete();
    endtask

    // Checks every pass cycle by cycle, feeding per-pass core spikes and scoreboarding out ids.
    task automatic run_passes(input logic [3:0] cap0, input logic [3:0] cap1, input logic [3:0] cap2,
                              input int stall_pass, input logic exp_final);
        logic [3:0] caps [3];
        int   n, id, got;
        logic h;
        logic [5:0] last_addr;
        caps[0] = cap0; caps[1] = cap1; caps[2] = cap2;
        n = model_buf.size();
        last_addr = (n > 0) ? 6'(model_buf[n-1]) : 6'd0;
        for (int p = 0; p < NPC; p++) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; in_null = 1'b0; in_final_ts = 1'b0;
            tests++;
            if ({nc_en_accum, nc_en_activ, nc_neuron, in_ready, nc_last_time_step, out_valid}
                !== {1'b1, 1'b0, 2'(p), 1'b0, exp_final, 1'b0}) begin
                fails++;
                $display("FAIL start p%0d: accum=%b activ=%b nrn=%0d rdy=%b lts=%b ov=%b want 1 0 %0d 0 %b 0",
                         p, nc_en_accum, nc_en_activ, nc_neuron, in_ready, nc_last_time_step, out_valid, p, exp_final);
            end
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                tests++;
                if ({nc_en_accum, nc_en_activ, nc_spk_addr, nc_neuron} !== {2'b00, 6'(model_buf[k]), 2'(p)}) begin
                    fails++;
                    $display("FAIL stream p%0d k%0d: accum=%b activ=%b addr=%0d nrn=%0d want 0 0 %0d %0d",
                             p, k, nc_en_accum, nc_en_activ, nc_spk_addr, nc_neuron, model_buf[k], p);
                end
            end
            @(negedge clk);
            tests++;
            if ({nc_en_accum, nc_en_activ, nc_spk_addr, nc_neuron} !== {2'b01, last_addr, 2'(p)}) begin
                fails++;
                $display("FAIL activ p%0d: accum=%b activ=%b addr=%0d nrn=%0d want 0 1 %0d %0d",
                         p, nc_en_accum, nc_en_activ, nc_spk_addr, nc_neuron, last_addr, p);
            end
            nc_post_syn_spk = caps[p];
            out_ready = (p == stall_pass) ? 1'b0 : 1'b1;
            for (int c = 0; c < NUM_NC; c++) begin
                if (caps[p][c] && (c * NPC + p) < LAYER_SIZE) exp_q.push_back(c * NPC + p);
            end
            for (int w = 0; w < 2; w++) begin
                @(negedge clk);
                tests++;
                if ({nc_en_accum, nc_en_activ, out_valid, nc_neuron} !== {3'b000, 2'(p)}) begin
                    fails++;
                    $display("FAIL wait p%0d w%0d: accum=%b activ=%b ov=%b nrn=%0d want 0 0 0 %0d",
                             p, w, nc_en_accum, nc_en_activ, out_valid, nc_neuron, p);
                end
            end
            for (int c = 0; c < NUM_NC; c++) begin
                @(negedge clk);
                if (c == 0) nc_post_syn_spk = 4'b0000;
                id = c * NPC + p;
                h = caps[p][c] && (id < LAYER_SIZE);
                tests++;
                if (out_valid !== h) begin
                    fails++;
                    $display("FAIL emit_valid p%0d c%0d: got %b want %b", p, c, out_valid, h);
                end
                if (out_valid === 1'b1) begin
                    got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    tests++;
                    if (out_neuron !== 4'(got)) begin
                        fails++;
                        $display("FAIL emit_id p%0d c%0d: got %0d want %0d", p, c, out_neuron, got);
                    end
                    if (p == stall_pass && out_ready === 1'b0) begin
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clk);
                            tests++;
                            if ({out_valid, out_neuron, in_ready, nc_en_accum} !== {1'b1, 4'(got), 2'b00}) begin
                                fails++;
                                $display("FAIL stall p%0d i%0d: ov=%b id=%0d rdy=%b accum=%b want 1 %0d 0 0",
                                         p, i, out_valid, out_neuron, in_ready, nc_en_accum, got);
                            end
                            if (i == 4) out_ready = 1'b1;
                        end
                    end
                end
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        tests++;
        if ({ts_done, nc_last_time_step, in_ready, out_valid} !== {1'b1, exp_final, 2'b00}) begin
            fails++;
            $display("FAIL done: tsd=%b lts=%b rdy=%b ov=%b want 1 %b 0 0", ts_done, nc_last_time_step, in_ready, out_valid, exp_final);
        end
        @(negedge clk);
        tests++;
        if ({ts_done, nc_last_time_step, in_ready, overflow} !== {3'b001, exp_ovf}) begin
            fails++;
            $display("FAIL reload: tsd=%b lts=%b rdy=%b ovf=%b want 0 0 1 %b", ts_done, nc_last_time_step, in_ready, overflow, exp_ovf);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: %0d ids never emitted, want 0", exp_q.size());
        end
        exp_q.delete();
        model_buf.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({in_ready, nc_en_accum, nc_en_activ, nc_last_time_step, nc_neuron, nc_spk_addr,
             out_valid, out_neuron, ts_done, overflow} !== {1'b1, 18'd0}) begin
            fails++;
            $display("FAIL reset_state: rdy=%b accum=%b activ=%b ov=%b tsd=%b ovf=%b want 1 0 0 0 0 0",
                     in_ready, nc_en_accum, nc_en_activ, out_valid, ts_done, overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        stim_q = '{3, 17, 40};
        load_ts(1'b0, 1'b0);
        run_passes(4'b0000, 4'b0000, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_emit_last_ts();
        stim_q = '{1, 2};
        load_ts(1'b0, 1'b1);
        run_passes(4'b1111, 4'b1010, 4'b1111, -1, 1'b1);
    endtask

    task automatic test_zero_spike();
        load_ts(1'b1, 1'b0);
        run_passes(4'b0000, 4'b0000, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_stall();
        stim_q = '{9};
        load_ts(1'b0, 1'b0);
        run_passes(4'b0001, 4'b0100, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 60; i++) stim_q.push_back(i % MAX_SPK);
        load_ts(1'b1, 1'b0);
        run_passes(4'b0000, 4'b1000, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        stim_q = '{5, 6, 7};
        load_ts(1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (nc_spk_addr !== 6'd6) begin
            fails++;
            $display("FAIL mid_stream_addr: got %0d want 6", nc_spk_addr);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, nc_en_accum, nc_en_activ, nc_last_time_step, nc_neuron, nc_spk_addr,
             out_valid, out_neuron, ts_done, overflow} !== {1'b1, 18'd0}) begin
            fails++;
            $display("FAIL mid_reset: rdy=%b accum=%b activ=%b addr=%0d ovf=%b want 1 0 0 0 0",
                     in_ready, nc_en_accum, nc_en_activ, nc_spk_addr, overflow);
        end
        model_buf.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stim_q = '{11, 22};
        load_ts(1'b0, 1'b0);
        run_passes(4'b0010, 4'b0000, 4'b0001, -1, 1'b0);
    endtask

    initial begin
        tests = 0; fails = 0; exp_ovf = 1'b0;
        in_valid = 1'b0; in_addr = 6'd0; in_last = 1'b0; in_null = 1'b0; in_final_ts = 1'b0;
        nc_post_syn_spk = 4'b0000; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_emit_last_ts();
        test_zero_spike();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
